// File: rtl/icape2_pkg.sv
// Shared constants, opcode and state types for the ICAPE2 responder.
package icape2_pkg;

    localparam logic [31:0] SYNC_WORD  = 32'hAA995566;
    localparam logic [31:0] NOOP_WORD  = 32'h20000000;
    localparam logic [31:0] DUMMY_WORD = 32'hFFFFFFFF;

    localparam logic [4:0] REG_CMD    = 5'h04;
    localparam logic [4:0] REG_IDCODE = 5'h0C;
    localparam logic [4:0] REG_WBSTAR = 5'h10;

    localparam logic [4:0] CMD_DESYNC = 5'h0D;
    localparam logic [4:0] CMD_IPROG  = 5'h0F;

    localparam logic [2:0] PKT_TYPE1 = 3'b001;
    localparam logic [2:0] PKT_TYPE2 = 3'b010;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_RSVD  = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_DESYNC,
        ST_HDR,
        ST_WDATA,
        ST_RWAIT,
        ST_RDATA,
        ST_ABORT
    } state_e;

endpackage

// File: rtl/icape2_bitswap.sv
// Reverses bit order inside each byte of a 32-bit word (raw ICAPE2 pin order).
module icape2_bitswap (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        for (genvar k = 0; k < 8; k++) begin : g_bit
            assign o_word[b*8+k] = i_word[b*8+7-k];
        end
    end

endmodule

// File: rtl/icape2_responder.sv
// Device-side model of the 7-series ICAPE2 port: packet decoder plus 32-entry register file.
// Optional macro ICAPE2_BITSWAP_EN: I/O words use per-byte bit-reversed primitive pin order.
module icape2_responder
    import icape2_pkg::*;
#(
    parameter int          READ_LAT = 3,
    parameter logic [31:0] ID_CODE  = 32'h0362D093
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_csn,
    input  logic        i_rdwrn,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_synced,
    output logic        o_abort,
    output logic        o_iprog,
    output logic [31:0] o_wbstar
);

    state_e      r_state;
    opcode_e     r_op;
    logic [26:0] r_cnt;
    logic [15:0] r_lat;
    logic [4:0]  r_addr;
    logic [31:0] r_data;
    logic        r_synced, r_abort, r_iprog, r_desync_pend;
    logic        r_prev_csn, r_prev_rdwrn;
    logic [31:0] r_wbstar;
    logic [31:0] r_regs [32];

    logic [31:0] w_word;
    logic        w_wr, w_rd, w_abort_evt;
    logic [2:0]  w_type;
    opcode_e     w_hdr_op, w_eff_op;
    logic [26:0] w_hdr_cnt;

    state_e      w_state_next;
    opcode_e     w_op_next;
    logic [26:0] w_cnt_next;
    logic [15:0] w_lat_next;
    logic [4:0]  w_addr_next;
    logic [31:0] w_data_next;
    logic        w_reg_we, w_clear_regs, w_iprog, w_desync_pend_next;

`ifdef ICAPE2_BITSWAP_EN
    icape2_bitswap u_swap_in  (.i_word(i_data), .o_word(w_word));
    icape2_bitswap u_swap_out (.i_word(r_data), .o_word(o_data));
`else
    assign w_word = i_data;
    assign o_data = r_data;
`endif

    assign w_wr = !i_csn && !i_rdwrn;
    assign w_rd = !i_csn &&  i_rdwrn;

    // Direction flip on two consecutive selected cycles is a protocol violation.
    assign w_abort_evt = !i_csn && !r_prev_csn && (i_rdwrn != r_prev_rdwrn) &&
                         (r_state inside {ST_HDR, ST_WDATA, ST_RWAIT, ST_RDATA});

    assign w_type    = w_word[31:29];
    assign w_hdr_op  = opcode_e'(w_word[28:27]);
    assign w_eff_op  = (w_type == PKT_TYPE1) ? w_hdr_op : r_op;
    assign w_hdr_cnt = (w_type == PKT_TYPE1) ? {16'd0, w_word[10:0]} :
                       (w_type == PKT_TYPE2) ? w_word[26:0] : 27'd0;

    always_comb begin
        w_state_next       = r_state;
        w_op_next          = r_op;
        w_cnt_next         = r_cnt;
        w_lat_next         = r_lat;
        w_addr_next        = r_addr;
        w_data_next        = DUMMY_WORD;
        w_reg_we           = 1'b0;
        w_clear_regs       = 1'b0;
        w_iprog            = 1'b0;
        w_desync_pend_next = r_desync_pend;
        if (w_abort_evt) begin
            w_state_next = ST_ABORT;
        end else begin
            case (r_state)
                ST_DESYNC: begin
                    if (w_wr && w_word == SYNC_WORD) w_state_next = ST_HDR;
                end
                ST_HDR: begin
                    if (w_wr) begin
                        if (w_type == PKT_TYPE1) begin
                            w_op_next   = w_hdr_op;
                            w_addr_next = w_word[17:13];
                        end
                        if (w_hdr_cnt != 27'd0) begin
                            if (w_eff_op == OP_WRITE) begin
                                w_state_next       = ST_WDATA;
                                w_cnt_next         = w_hdr_cnt;
                                w_desync_pend_next = 1'b0;
                            end else if (w_eff_op == OP_READ) begin
                                w_state_next = ST_RWAIT;
                                w_cnt_next   = w_hdr_cnt;
                                w_lat_next   = 16'd0;
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (w_wr) begin
                        w_cnt_next = r_cnt - 27'd1;
                        if (r_addr == REG_CMD && w_word == {27'd0, CMD_IPROG}) begin
                            w_iprog      = 1'b1;
                            w_clear_regs = 1'b1;
                            w_state_next = ST_DESYNC;
                        end else begin
                            w_reg_we           = (r_addr != REG_IDCODE);
                            w_desync_pend_next = r_desync_pend ||
                                (r_addr == REG_CMD && w_word == {27'd0, CMD_DESYNC});
                            if (r_cnt == 27'd1)
                                w_state_next = w_desync_pend_next ? ST_DESYNC : ST_HDR;
                        end
                    end
                end
                ST_RWAIT: begin
                    if (w_rd) begin
                        w_lat_next = r_lat + 16'd1;
                        if (int'(r_lat) + 1 >= READ_LAT) begin
                            w_data_next  = r_regs[r_addr];
                            w_state_next = ST_RDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (w_rd) begin
                        w_cnt_next = r_cnt - 27'd1;
                        if (r_cnt == 27'd1) w_state_next = ST_HDR;
                        else                w_data_next  = r_regs[r_addr];
                    end else if (w_wr) begin
                        w_cnt_next   = 27'd0;
                        w_state_next = ST_HDR;
                    end else begin
                        w_data_next = r_data;
                    end
                end
                ST_ABORT: begin
                    if (i_csn) w_state_next = ST_DESYNC;
                end
                default: w_state_next = ST_DESYNC;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_DESYNC;
            r_op          <= OP_NOP;
            r_cnt         <= 27'd0;
            r_lat         <= 16'd0;
            r_addr        <= 5'd0;
            r_data        <= DUMMY_WORD;
            r_synced      <= 1'b0;
            r_abort       <= 1'b0;
            r_iprog       <= 1'b0;
            r_desync_pend <= 1'b0;
            r_prev_csn    <= 1'b1;
            r_prev_rdwrn  <= 1'b0;
            r_wbstar      <= 32'd0;
            for (int i = 0; i < 32; i++)
                r_regs[i] <= (5'(i) == REG_IDCODE) ? ID_CODE : 32'd0;
        end else begin
            r_state       <= w_state_next;
            r_op          <= w_op_next;
            r_cnt         <= w_cnt_next;
            r_lat         <= w_lat_next;
            r_addr        <= w_addr_next;
            r_data        <= w_data_next;
            r_synced      <= (w_state_next != ST_DESYNC);
            r_abort       <= (w_state_next == ST_ABORT);
            r_iprog       <= w_iprog;
            r_desync_pend <= w_desync_pend_next;
            r_prev_csn    <= i_csn;
            r_prev_rdwrn  <= i_rdwrn;
            r_wbstar      <= r_regs[REG_WBSTAR];
            if (w_clear_regs) begin
                for (int i = 0; i < 32; i++)
                    if (5'(i) != REG_WBSTAR && 5'(i) != REG_IDCODE) r_regs[i] <= 32'd0;
            end else if (w_reg_we) begin
                r_regs[r_addr] <= w_word;
            end
        end
    end

    assign o_synced = r_synced;
    assign o_abort  = r_abort;
    assign o_iprog  = r_iprog;
    assign o_wbstar = r_wbstar;

endmodule

// File: tb/tb_icape2_responder.sv
// Directed self-checking bench for icape2_responder (default build, logical word order).
module tb_icape2_responder;
    import icape2_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset, i_csn, i_rdwrn;
    logic [31:0] i_data;
    logic [31:0] o_data, o_wbstar;
    logic        o_synced, o_abort, o_iprog;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] ID = 32'h0362D093;
    localparam logic [31:0] FF = 32'hFFFFFFFF;

    icape2_responder dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_csn    (i_csn),
        .i_rdwrn  (i_rdwrn),
        .i_data   (i_data),
        .o_data   (o_data),
        .o_synced (o_synced),
        .o_abort  (o_abort),
        .o_iprog  (o_iprog),
        .o_wbstar (o_wbstar)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One cycle: inputs change at negedge, returns 1 ns after the consuming posedge.
    task automatic step(input logic csn, input logic rw, input logic [31:0] d);
        @(negedge i_clk);
        i_csn = csn; i_rdwrn = rw; i_data = d;
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d);
        step(1'b0, 1'b0, d);
    endtask

    // Active read cycle; o_data seen by the host during this cycle is checked against the queue head.
    task automatic rd(input string tag);
        logic [31:0] exp;
        @(negedge i_clk);
        i_csn = 1'b0; i_rdwrn = 1'b1; i_data = 32'd0;
        #1;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hBAD0BAD0;
        check(tag, o_data, exp);
        @(posedge i_clk);
        #1;
    endtask

    task automatic expect_read(input logic [31:0] word);
        exp_q.push_back(FF); exp_q.push_back(FF); exp_q.push_back(FF);
        exp_q.push_back(word);
    endtask

    initial begin
        i_reset = 1'b1; i_csn = 1'b1; i_rdwrn = 1'b0; i_data = 32'd0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_data", o_data, FF);
        check("rst_synced", 32'(o_synced), 32'd0);
        check("rst_abort", 32'(o_abort), 32'd0);
        check("rst_iprog", 32'(o_iprog), 32'd0);
        check("rst_wbstar", o_wbstar, 32'd0);
        i_reset = 1'b0;

        // WBSTAR write then DESYNC
        wr(DUMMY_WORD); wr(NOOP_WORD);
        check("t1_presync", 32'(o_synced), 32'd0);
        wr(SYNC_WORD);
        check("t1_synced", 32'(o_synced), 32'd1);
        wr(NOOP_WORD); wr(NOOP_WORD);
        wr(32'h30020001); wr(32'h00400000);
        wr(32'h30008001);
        check("t1_wbstar", o_wbstar, 32'h00400000);
        wr(32'h0000000D);
        check("t1_desync", 32'(o_synced), 32'd0);

        // IDCODE read with latency
        step(1'b1, 1'b0, 32'd0);
        wr(SYNC_WORD); wr(32'h28018001); wr(NOOP_WORD); wr(NOOP_WORD);
        step(1'b1, 1'b0, 32'd0);
        expect_read(ID);
        for (int i = 0; i < 4; i++) rd("t2_idcode");
        check("t2_after", o_data, FF);
        step(1'b1, 1'b1, 32'd0);

        // Register 1 write/readback, then IPROG clears it but keeps WBSTAR
        wr(32'h30002001); wr(32'hDEADBEEF);
        wr(32'h28002001); wr(NOOP_WORD);
        step(1'b1, 1'b0, 32'd0);
        expect_read(32'hDEADBEEF);
        for (int i = 0; i < 4; i++) rd("t3_reg1");
        step(1'b1, 1'b1, 32'd0);
        wr(32'h30008001); wr(32'h0000000F);
        check("t3_iprog_hi", 32'(o_iprog), 32'd1);
        check("t3_synced", 32'(o_synced), 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("t3_iprog_lo", 32'(o_iprog), 32'd0);
        check("t3_wbstar", o_wbstar, 32'h00400000);
        wr(SYNC_WORD); wr(32'h28002001);
        step(1'b1, 1'b0, 32'd0);
        expect_read(32'd0);
        for (int i = 0; i < 4; i++) rd("t3_reg1_clr");
        step(1'b1, 1'b1, 32'd0);
        wr(32'h30008001); wr(32'h0000000D);

        // Abort on direction flip while selected
        wr(SYNC_WORD);
        step(1'b0, 1'b1, 32'd0);
        check("t4_abort", 32'(o_abort), 32'd1);
        check("t4_data", o_data, FF);
        step(1'b1, 1'b1, 32'd0);
        check("t4_abort_clr", 32'(o_abort), 32'd0);
        check("t4_synced", 32'(o_synced), 32'd0);
        wr(32'h30008001); wr(32'h0000000F);
        check("t4_ignored", 32'(o_iprog), 32'd0);

        // IDCODE is read-only; type-2 write to WBSTAR
        wr(SYNC_WORD); wr(32'h30018001); wr(32'h12345678);
        wr(32'h28018001); wr(NOOP_WORD);
        step(1'b1, 1'b0, 32'd0);
        expect_read(ID);
        for (int i = 0; i < 4; i++) rd("t5_idcode_ro");
        step(1'b1, 1'b1, 32'd0);
        wr(32'h30020000); wr(32'h50000003);
        wr(32'h11111111); wr(32'h22222222); wr(32'h33333333);
        check("t5_wbstar_lag", o_wbstar, 32'h22222222);
        wr(NOOP_WORD);
        check("t5_wbstar", o_wbstar, 32'h33333333);

        // Reset in the middle of a two-word read
        wr(32'h28020002);
        step(1'b1, 1'b0, 32'd0);
        expect_read(32'h33333333);
        for (int i = 0; i < 4; i++) rd("t6_wbstar_rd");
        check("t6_rdata", o_data, 32'h33333333);
        @(negedge i_clk);
        i_reset = 1'b1; i_csn = 1'b0; i_rdwrn = 1'b1;
        @(posedge i_clk);
        #1;
        check("t6_rst_data", o_data, FF);
        check("t6_rst_synced", 32'(o_synced), 32'd0);
        check("t6_rst_wbstar", o_wbstar, 32'd0);
        i_reset = 1'b0;
        step(1'b1, 1'b1, 32'd0);
        wr(32'h30008001); wr(32'h0000000F);
        check("t6_desync", 32'(o_iprog), 32'd0);
        wr(SYNC_WORD); wr(32'h28020001);
        step(1'b1, 1'b0, 32'd0);
        expect_read(32'd0);
        for (int i = 0; i < 4; i++) rd("t6_wbstar_clr");
        check("q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
